instruction_fetch_unit: RTL
===========================

# instruction_fetch_unit

Instruction fetch stage. Owns the PC, issues one-at-a-time requests to instruction memory, and produces the instruction word plus stall/bubble flag consumed by the fetch/decoder pipeline register. Handles decoder back-pressure with a one-entry hold buffer. Accepts branch/jump redirects, discarding any in-flight or held wrong-path fetch.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- sys_clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-high.
- imem_req  out  1  request valid; combinational, high exactly in state S_REQ.
- imem_addr  out  32  request address, equals pc.
- imem_ready  in  1  memory accepts request this cycle (sampled only while imem_req=1).
- imem_rvalid  in  1  response valid; meaningful only in S_WAIT.
- imem_rdata  in  32  response instruction word.
- stall_in  in  1  decoder cannot accept a new instruction this cycle.
- redirect_valid  in  1  branch/jump taken; load redirect_pc.
- redirect_pc  in  32  redirect target; bits [1:0] ignored, stored as 0.
- out_ins  out  32  instruction to decoder register; 32'b0 when bubble.
- out_is_stalling  out  1  1 = out_ins is a bubble, 0 = valid instruction.
- out_pc  out  32  PC of out_ins; 0 when bubble.

## Operation
- State: pc[31:0], state in {S_REQ, S_WAIT, S_HOLD}, kill flag, hold_ins[31:0].
- Outputs out_* are registered. Default every cycle: out_ins<=0, out_is_stalling<=1, out_pc<=0. Valid instruction shown for exactly one cycle.
- S_REQ: imem_req=1, imem_addr=pc.
  - redirect_valid: pc<=redirect_pc; if imem_ready also high -> S_WAIT with kill<=1 (old-pc request already accepted), else stay S_REQ.
  - else imem_ready: -> S_WAIT, kill<=0.
- S_WAIT: imem_req=0.
  - redirect_valid (with or without rvalid): pc<=redirect_pc; if rvalid -> S_REQ, kill<=0 (data dropped); else kill<=1, stay.
  - rvalid && kill: drop data, kill<=0, -> S_REQ (pc already redirected).
  - rvalid && !kill && !stall_in: out_ins<=rdata, out_is_stalling<=0, out_pc<=pc, pc<=pc+4, -> S_REQ.
  - rvalid && !kill && stall_in: hold_ins<=rdata, -> S_HOLD.
- S_HOLD: imem_req=0, rvalid ignored.
  - redirect_valid: drop hold_ins, pc<=redirect_pc, -> S_REQ (redirect beats stall release).
  - !stall_in: out_ins<=hold_ins, out_is_stalling<=0, out_pc<=pc, pc<=pc+4, -> S_REQ.
  - stall_in: stay.
- rvalid outside S_WAIT ignored. imem_ready outside S_REQ ignored.
- PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.

## Timing
- Reset (async assert, any state): pc=RESET_PC, state=S_REQ, kill=0, hold_ins=0, out_ins=0, out_is_stalling=1, out_pc=0. imem_req goes 0 while rst high, 1 in first cycle after release.
- Minimum fetch: request accepted cycle N, rvalid in N+1, instruction on outputs N+2, next request N+2. Throughput ≤1 instruction / 2 cycles.
- Stall during S_HOLD: outputs bubble every cycle; held instruction appears the cycle after the first edge with stall_in=0.
- Redirect effect: next accepted request in S_REQ uses redirect_pc; no wrong-path instruction ever reaches outputs after the edge where redirect_valid was sampled.
- Reset mid-fetch: outstanding memory response after reset release arrives while in S_REQ and is ignored; memory must not return rvalid for a pre-reset request after a new request is accepted.

## Test plan
- Reset: RESET_PC=32'h0040_0000, hold rst 3 cycles -> out_is_stalling=1, out_ins=0, imem_req=0; after release imem_addr=32'h0040_0000, imem_req=1.
- Straight line: ready=1 always, rvalid 1 cycle after accept, rdata=addr^32'hA5A5_A5A5 -> outputs show pc 0x400000, 0x400004, 0x400008 every 2 cycles with matching data, bubbles between.
- Back-pressure: stall_in=1 when rdata=32'h2108_0001 returns, held 4 cycles -> 4+ bubble cycles, no new imem_req; stall release -> out_ins=32'h2108_0001 once, then request at pc+4.
- Redirect in S_WAIT: redirect_pc=32'h0040_0103 one cycle before rvalid -> returned word discarded, next imem_addr=32'h0040_0100, no wrong-path output.
- Redirect same cycle as accept and as stall release in S_HOLD -> both discard; next request at redirect target; held instruction never output.
- Wrap: redirect to 32'hFFFF_FFFC, fetch completes -> out_pc=32'hFFFF_FFFC, next imem_addr=32'h0000_0000; then assert rst while in S_WAIT -> immediate reset values, stale rvalid ignored.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one memory request at a time, buffers one
// instruction under decoder back-pressure and squashes wrong-path fetches on redirect.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        sys_clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] out_ins,
    output logic        out_is_stalling,
    output logic [31:0] out_pc
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_r, state_nxt_s;
    logic [31:0] pc_r, pc_nxt_s;
    logic        kill_r, kill_nxt_s;
    logic [31:0] hold_ins_r, hold_ins_nxt_s;
    logic [31:0] out_ins_r, out_ins_nxt_s;
    logic        out_stall_r, out_stall_nxt_s;
    logic [31:0] out_pc_r, out_pc_nxt_s;
    logic [31:0] redirect_aligned_s;
    logic [31:0] pc_plus4_s;

    assign redirect_aligned_s = redirect_pc & 32'hFFFF_FFFC;
    assign pc_plus4_s         = pc_r + 32'd4;

    // Request is combinational on state; suppressed while reset is held.
    assign imem_req        = (state_r == S_REQ) && !rst;
    assign imem_addr       = pc_r;
    assign out_ins         = out_ins_r;
    assign out_is_stalling = out_stall_r;
    assign out_pc          = out_pc_r;

    // State, PC, kill flag, hold buffer and registered outputs.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_REQ;
            pc_r        <= RESET_PC & 32'hFFFF_FFFC;
            kill_r      <= 1'b0;
            hold_ins_r  <= 32'h0000_0000;
            out_ins_r   <= 32'h0000_0000;
            out_stall_r <= 1'b1;
            out_pc_r    <= 32'h0000_0000;
        end else begin
            state_r     <= state_nxt_s;
            pc_r        <= pc_nxt_s;
            kill_r      <= kill_nxt_s;
            hold_ins_r  <= hold_ins_nxt_s;
            out_ins_r   <= out_ins_nxt_s;
            out_stall_r <= out_stall_nxt_s;
            out_pc_r    <= out_pc_nxt_s;
        end
    end

    // Next-state logic; outputs default to a bubble so a valid word lasts one cycle.
    always_comb begin
        state_nxt_s     = state_r;
        pc_nxt_s        = pc_r;
        kill_nxt_s      = kill_r;
        hold_ins_nxt_s  = hold_ins_r;
        out_ins_nxt_s   = 32'h0000_0000;
        out_stall_nxt_s = 1'b1;
        out_pc_nxt_s    = 32'h0000_0000;
        case (state_r)
            S_REQ: begin
                if (redirect_valid) begin
                    pc_nxt_s = redirect_aligned_s;
                    // An accepted old-pc request still returns data that must be dropped.
                    if (imem_ready) begin
                        state_nxt_s = S_WAIT;
                        kill_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = S_REQ;
                    end
                end else if (imem_ready) begin
                    state_nxt_s = S_WAIT;
                    kill_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s = S_REQ;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_nxt_s = redirect_aligned_s;
                    if (imem_rvalid) begin
                        state_nxt_s = S_REQ;
                        kill_nxt_s  = 1'b0;
                    end else begin
                        kill_nxt_s  = 1'b1;
                    end
                end else if (imem_rvalid && kill_r) begin
                    kill_nxt_s  = 1'b0;
                    state_nxt_s = S_REQ;
                end else if (imem_rvalid && !stall_in) begin
                    out_ins_nxt_s   = imem_rdata;
                    out_stall_nxt_s = 1'b0;
                    out_pc_nxt_s    = pc_r;
                    pc_nxt_s        = pc_plus4_s;
                    state_nxt_s     = S_REQ;
                end else if (imem_rvalid) begin
                    hold_ins_nxt_s = imem_rdata;
                    state_nxt_s    = S_HOLD;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            S_HOLD: begin
                // Redirect wins over stall release: the held word is wrong-path.
                if (redirect_valid) begin
                    pc_nxt_s    = redirect_aligned_s;
                    state_nxt_s = S_REQ;
                end else if (!stall_in) begin
                    out_ins_nxt_s   = hold_ins_r;
                    out_stall_nxt_s = 1'b0;
                    out_pc_nxt_s    = pc_r;
                    pc_nxt_s        = pc_plus4_s;
                    state_nxt_s     = S_REQ;
                end else begin
                    state_nxt_s = S_HOLD;
                end
            end
            default: begin
                state_nxt_s = S_REQ;
                kill_nxt_s  = 1'b0;
            end
        endcase
    end

endmodule
